// File: rtl/pipe_ctrl.sv
// Hazard/stall/forwarding controller for a 5-stage in-order pipeline.
// Holds EX/MEM/WB shadow copies of the control fields and drives register enables, flushes and forwarding selects.
module pipe_ctrl #(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic                   id_rf_en,
  input  logic                   id_is_load,
  input  logic                   id_is_mem,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic [4:0]             id_rd,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  input  logic                   ex_br_taken,
  input  logic                   dmem_ack,
  output logic                   pc_en,
  output logic                   ifid_en,
  output logic                   idex_en,
  output logic                   exmem_en,
  output logic                   memwb_en,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   pc_sel,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic                   dmem_req,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t state_q, state_d;

  logic       ex_valid_q, ex_rf_en_q, ex_is_load_q, ex_is_mem_q;
  logic [4:0] ex_rd_q, ex_rs1_q, ex_rs2_q;
  logic       ex_valid_d, ex_rf_en_d, ex_is_load_d, ex_is_mem_d;
  logic [4:0] ex_rd_d, ex_rs1_d, ex_rs2_d;

  logic       mem_valid_q, mem_rf_en_q, mem_is_load_q, mem_is_mem_q;
  logic [4:0] mem_rd_q;
  logic       mem_valid_d, mem_rf_en_d, mem_is_load_d, mem_is_mem_d;
  logic [4:0] mem_rd_d;

  logic       wb_valid_q, wb_rf_en_q, wb_is_load_q, wb_is_mem_q;
  logic [4:0] wb_rd_q;
  logic       wb_valid_d, wb_rf_en_d, wb_is_load_d, wb_is_mem_d;
  logic [4:0] wb_rd_d;

  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic mem_stall, br_take, load_use;
  logic mem_fwd_ok, wb_fwd_ok;
  logic unused_wb;

  // WB load/store flags are tracked for completeness but nothing downstream consumes them.
  assign unused_wb = wb_is_load_q ^ wb_is_mem_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= RUN;
      ex_valid_q    <= 1'b0;
      ex_rf_en_q    <= 1'b0;
      ex_is_load_q  <= 1'b0;
      ex_is_mem_q   <= 1'b0;
      ex_rd_q       <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      mem_valid_q   <= 1'b0;
      mem_rf_en_q   <= 1'b0;
      mem_is_load_q <= 1'b0;
      mem_is_mem_q  <= 1'b0;
      mem_rd_q      <= '0;
      wb_valid_q    <= 1'b0;
      wb_rf_en_q    <= 1'b0;
      wb_is_load_q  <= 1'b0;
      wb_is_mem_q   <= 1'b0;
      wb_rd_q       <= '0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      ex_valid_q    <= ex_valid_d;
      ex_rf_en_q    <= ex_rf_en_d;
      ex_is_load_q  <= ex_is_load_d;
      ex_is_mem_q   <= ex_is_mem_d;
      ex_rd_q       <= ex_rd_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      mem_valid_q   <= mem_valid_d;
      mem_rf_en_q   <= mem_rf_en_d;
      mem_is_load_q <= mem_is_load_d;
      mem_is_mem_q  <= mem_is_mem_d;
      mem_rd_q      <= mem_rd_d;
      wb_valid_q    <= wb_valid_d;
      wb_rf_en_q    <= wb_rf_en_d;
      wb_is_load_q  <= wb_is_load_d;
      wb_is_mem_q   <= wb_is_mem_d;
      wb_rd_q       <= wb_rd_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  // The frozen MEM shadow keeps dmem_req high while waiting, so the state
  // tracks the outstanding access and leaves as soon as it is acknowledged.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (dmem_req && !dmem_ack) state_d = MEM_WAIT;
      MEM_WAIT: if (dmem_ack || !dmem_req) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_comb begin
    dmem_req  = mem_valid_q & mem_is_mem_q;
    mem_stall = dmem_req & ~dmem_ack;
    br_take   = ex_valid_q & ex_br_taken;
    load_use  = id_valid & ex_valid_q & ex_is_load_q & (ex_rd_q != 5'd0) &
                ((id_use_rs1 & (id_rs1 == ex_rd_q)) | (id_use_rs2 & (id_rs2 == ex_rd_q)));

    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pc_sel     = 1'b0;

    if (mem_stall) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (br_take) begin
      pc_sel     = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end

    mem_fwd_ok = mem_valid_q & mem_rf_en_q & ~mem_is_load_q & (mem_rd_q != 5'd0);
    wb_fwd_ok  = wb_valid_q & wb_rf_en_q & (wb_rd_q != 5'd0);

    fwd_a = 2'b00;
    if (mem_fwd_ok && (mem_rd_q == ex_rs1_q))     fwd_a = 2'b01;
    else if (wb_fwd_ok && (wb_rd_q == ex_rs1_q))  fwd_a = 2'b10;

    fwd_b = 2'b00;
    if (mem_fwd_ok && (mem_rd_q == ex_rs2_q))     fwd_b = 2'b01;
    else if (wb_fwd_ok && (wb_rd_q == ex_rs2_q))  fwd_b = 2'b10;

    stall_cnt = stall_cnt_q;
  end

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_rf_en_d    = ex_rf_en_q;
    ex_is_load_d  = ex_is_load_q;
    ex_is_mem_d   = ex_is_mem_q;
    ex_rd_d       = ex_rd_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    mem_valid_d   = mem_valid_q;
    mem_rf_en_d   = mem_rf_en_q;
    mem_is_load_d = mem_is_load_q;
    mem_is_mem_d  = mem_is_mem_q;
    mem_rd_d      = mem_rd_q;
    wb_valid_d    = wb_valid_q;
    wb_rf_en_d    = wb_rf_en_q;
    wb_is_load_d  = wb_is_load_q;
    wb_is_mem_d   = wb_is_mem_q;
    wb_rd_d       = wb_rd_q;
    stall_cnt_d   = stall_cnt_q;

    // A bubble clears the whole EX slot so stale source indices cannot steer forwarding.
    if (idex_en) begin
      if (idex_flush) begin
        ex_valid_d   = 1'b0;
        ex_rf_en_d   = 1'b0;
        ex_is_load_d = 1'b0;
        ex_is_mem_d  = 1'b0;
        ex_rd_d      = '0;
        ex_rs1_d     = '0;
        ex_rs2_d     = '0;
      end else begin
        ex_valid_d   = id_valid;
        ex_rf_en_d   = id_rf_en;
        ex_is_load_d = id_is_load;
        ex_is_mem_d  = id_is_mem;
        ex_rd_d      = id_rd;
        ex_rs1_d     = id_rs1;
        ex_rs2_d     = id_rs2;
      end
    end

    if (exmem_en) begin
      mem_valid_d   = ex_valid_q;
      mem_rf_en_d   = ex_rf_en_q;
      mem_is_load_d = ex_is_load_q;
      mem_is_mem_d  = ex_is_mem_q;
      mem_rd_d      = ex_rd_q;
    end

    if (memwb_en) begin
      wb_valid_d   = mem_valid_q;
      wb_rf_en_d   = mem_rf_en_q;
      wb_is_load_d = mem_is_load_q;
      wb_is_mem_d  = mem_is_mem_q;
      wb_rd_d      = mem_rd_q;
    end

    if (!pc_en && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

endmodule
